// File: rtl/pad_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pad_seq_pkg
//  Description : Shared types and helpers for the pad sequencer: state
//                encoding, default group count and timer width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pad_seq_pkg;

    // Encoding is visible on state_o, so values are fixed.
    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_ON        = 3'd3,
        ST_RAMP_DOWN = 3'd4
    } state_t;

    localparam int c_n_grp_default      = 4;
    localparam int c_settle_cyc_default = 16;
    localparam int c_step_cyc_default   = 8;

    // Timer must hold the larger of the two reload values.
    function automatic int tmr_width(input int settle_cyc, input int step_cyc);
        int mx;
        mx = (settle_cyc > step_cyc) ? settle_cyc : step_cyc;
        return $clog2(mx + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pad_seq_tmr.sv
`default_nettype none
// ============================================================================
//  Module      : pad_seq_tmr
//  Description : Loadable down-counter. A load of value L raises expired_o
//                on the L-th cycle after the load, so the owner acts on the
//                edge exactly L cycles after loading.
//  Revision    : 1.0 - initial release
// ============================================================================
module pad_seq_tmr #(
    parameter int TW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          expired_o
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: reload wins, otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last counting cycle; zero means idle and never expires.
    assign expired_o = (cnt_q == TW'(1));

endmodule
`default_nettype wire

// File: rtl/pad_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pad_seq
//  Description : Pad ring sequencer. Holds output pads tristated with pulls
//                on, waits for supplies to settle, then enables output groups
//                one per step; on shutdown disables them highest first.
//                Outputs drive pad OEN/REN directly; keep this module
//                dont_touch in the constraints together with the pads.
//  Revision    : 1.0 - initial release
// ============================================================================
module pad_seq
    import pad_seq_pkg::*;
#(
    parameter int N_GRP      = c_n_grp_default,
    parameter int SETTLE_CYC = c_settle_cyc_default,
    parameter int STEP_CYC   = c_step_cyc_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             off_req_i,
    output logic [N_GRP-1:0] pad_oen_o,
    output logic             pad_ren_o,
    output logic             ready_o,
    output logic             off_ack_o,
    output logic [2:0]       state_o
);

    localparam int TW = tmr_width(SETTLE_CYC, STEP_CYC);
    localparam int NW = $clog2(N_GRP + 1);

    state_t           state_q, state_d;
    logic [NW-1:0]    n_q, n_d;
    logic [N_GRP-1:0] oen_q, oen_d;
    logic             ren_q, ren_d;
    logic             ready_q, ready_d;
    logic             ack_q, ack_d;

    logic             w_go;
    logic             w_tmr_load;
    logic [TW-1:0]    w_tmr_val;
    logic             w_tmr_exp;

    assign w_go = en_i & ~off_req_i;

    pad_seq_tmr #(
        .TW (TW)
    ) u_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .expired_o  (w_tmr_exp)
    );

    // Sequencing decisions: next state, group count and timer reloads.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        ack_d      = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_val  = TW'(STEP_CYC);
        case (state_q)
            ST_OFF: begin
                n_d = '0;
                if (w_go) begin
                    state_d    = ST_SETTLE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TW'(SETTLE_CYC);
                end
            end
            ST_SETTLE: begin
                if (!w_go) begin
                    state_d = ST_OFF;
                    n_d     = '0;
                end else if (w_tmr_exp) begin
                    state_d    = ST_RAMP_UP;
                    n_d        = NW'(1);
                    w_tmr_load = 1'b1;
                end
            end
            ST_RAMP_UP: begin
                // Losing go outranks a coincident step.
                if (!w_go) begin
                    state_d    = ST_RAMP_DOWN;
                    n_d        = n_q - NW'(1);
                    w_tmr_load = 1'b1;
                end else if (w_tmr_exp) begin
                    if (n_q < NW'(N_GRP)) begin
                        n_d        = n_q + NW'(1);
                        w_tmr_load = 1'b1;
                    end else begin
                        state_d = ST_ON;
                    end
                end
            end
            ST_ON: begin
                if (!w_go) begin
                    state_d    = ST_RAMP_DOWN;
                    n_d        = n_q - NW'(1);
                    w_tmr_load = 1'b1;
                end
            end
            ST_RAMP_DOWN: begin
                // go is ignored here: a started shutdown always finishes.
                if (w_tmr_exp) begin
                    if (n_q != '0) begin
                        n_d        = n_q - NW'(1);
                        w_tmr_load = 1'b1;
                    end else begin
                        state_d = ST_OFF;
                        ack_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
                n_d     = '0;
            end
        endcase
    end

    // Pad-facing values derived from the next state so they register cleanly.
    always_comb begin
        oen_d = '1;
        for (int i = 0; i < N_GRP; i++) begin
            oen_d[i] = !(NW'(i) < n_d);
        end
        ren_d   = (state_d == ST_ON);
        ready_d = (state_d == ST_ON);
    end

    // State and output registers; reset drops straight to safe pad values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            n_q     <= '0;
            oen_q   <= '1;
            ren_q   <= 1'b0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            oen_q   <= oen_d;
            ren_q   <= ren_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
        end
    end

    assign pad_oen_o = oen_q;
    assign pad_ren_o = ren_q;
    assign ready_o   = ready_q;
    assign off_ack_o = ack_q;
    assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pad_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pad_seq
//  Description : Self-checking bench for pad_seq. A time-based reference
//                model predicts every output each cycle; directed scenarios
//                add fixed-cycle checks, then a long randomized run follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pad_seq;

    localparam int N_GRP      = 4;
    localparam int SETTLE_CYC = 16;
    localparam int STEP_CYC   = 8;

    localparam int M_OFF  = 0;
    localparam int M_SET  = 1;
    localparam int M_UP   = 2;
    localparam int M_ON   = 3;
    localparam int M_DOWN = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en_i = 1'b0;
    logic             off_req_i = 1'b0;
    logic [N_GRP-1:0] pad_oen_o;
    logic             pad_ren_o;
    logic             ready_o;
    logic             off_ack_o;
    logic [2:0]       state_o;

    int n_tests = 0;
    int n_fail  = 0;
    int gcyc    = 0;
    int cyc     = 0;

    // Reference model: mode, entry edge of that mode, groups at ramp-down start.
    int m_mode = M_OFF;
    int m_t    = 0;
    int m_top  = 0;
    int m_n    = 0;
    bit m_ack  = 1'b0;

    pad_seq #(
        .N_GRP      (N_GRP),
        .SETTLE_CYC (SETTLE_CYC),
        .STEP_CYC   (STEP_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en_i),
        .off_req_i (off_req_i),
        .pad_oen_o (pad_oen_o),
        .pad_ren_o (pad_ren_o),
        .ready_o   (ready_o),
        .off_ack_o (off_ack_o),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (edge %0d)", tag, obs, exp, gcyc);
        end
    endtask

    // Group count is derived from time elapsed in the current mode.
    task automatic model_step(input bit r, input bit go);
        int el;
        m_ack = 1'b0;
        if (r) begin
            m_mode = M_OFF;
            m_n    = 0;
        end else begin
            el = gcyc - m_t;
            case (m_mode)
                M_OFF: if (go) begin m_mode = M_SET; m_t = gcyc; end
                M_SET: begin
                    if (!go) m_mode = M_OFF;
                    else if (el == SETTLE_CYC) begin m_mode = M_UP; m_t = gcyc; end
                end
                M_UP: begin
                    if (!go) begin m_top = m_n; m_mode = M_DOWN; m_t = gcyc; end
                    else if (el == N_GRP * STEP_CYC) m_mode = M_ON;
                end
                M_ON: if (!go) begin m_top = N_GRP; m_mode = M_DOWN; m_t = gcyc; end
                M_DOWN: if (el == m_top * STEP_CYC) begin m_mode = M_OFF; m_ack = 1'b1; end
                default: m_mode = M_OFF;
            endcase
            el = gcyc - m_t;
            case (m_mode)
                M_UP:    m_n = 1 + el / STEP_CYC;
                M_ON:    m_n = N_GRP;
                M_DOWN:  m_n = m_top - 1 - el / STEP_CYC;
                default: m_n = 0;
            endcase
        end
    endtask

    // One clock: apply inputs, advance model, check every output after the edge.
    task automatic step(input bit r, input bit e, input bit o);
        logic [31:0] exp_oen;
        rst       = r;
        en_i      = e;
        off_req_i = o;
        @(posedge clk);
        gcyc++;
        cyc++;
        model_step(r, e & ~o);
        #1;
        exp_oen = ~((32'd1 << m_n) - 32'd1) & ((32'd1 << N_GRP) - 32'd1);
        chk("state", 32'(state_o), 32'(m_mode));
        chk("oen",   32'(pad_oen_o), exp_oen);
        chk("ren",   32'(pad_ren_o), 32'(m_mode == M_ON));
        chk("ready", 32'(ready_o), 32'(m_mode == M_ON));
        chk("ack",   32'(off_ack_o), 32'(m_ack));
    endtask

    // Three reset cycles with random inputs; scenario cycle numbering restarts.
    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
            chk("rst_oen",   32'(pad_oen_o), 'hF);
            chk("rst_ren",   32'(pad_ren_o), 0);
            chk("rst_ready", 32'(ready_o), 0);
            chk("rst_ack",   32'(off_ack_o), 0);
            chk("rst_state", 32'(state_o), 0);
        end
        cyc = 0;
    endtask

    initial begin
        int acks;
        bit e, o, r;

        // Power-up then shutdown request at cycle 60.
        do_reset();
        for (int c = 1; c <= 100; c++) begin
            step(1'b0, 1'b1, (c - 1) >= 60);
            case (cyc)
                1:  chk("pu_settle", 32'(state_o), 1);
                17: chk("pu_oen17", 32'(pad_oen_o), 'hE);
                25: chk("pu_oen25", 32'(pad_oen_o), 'hC);
                33: chk("pu_oen33", 32'(pad_oen_o), 'h8);
                41: chk("pu_oen41", 32'(pad_oen_o), 'h0);
                48: chk("pu_ready48", 32'(ready_o), 0);
                49: begin
                    chk("pu_ready49", 32'(ready_o), 1);
                    chk("pu_ren49", 32'(pad_ren_o), 1);
                end
                61: begin
                    chk("dn_oen61", 32'(pad_oen_o), 'h8);
                    chk("dn_ready61", 32'(ready_o), 0);
                    chk("dn_ren61", 32'(pad_ren_o), 0);
                end
                69: chk("dn_oen69", 32'(pad_oen_o), 'hC);
                77: chk("dn_oen77", 32'(pad_oen_o), 'hE);
                85: chk("dn_oen85", 32'(pad_oen_o), 'hF);
                92: chk("dn_ack92", 32'(off_ack_o), 0);
                93: begin
                    chk("dn_ack93", 32'(off_ack_o), 1);
                    chk("dn_state93", 32'(state_o), 0);
                end
                94: chk("dn_ack94", 32'(off_ack_o), 0);
                default: ;
            endcase
        end

        // en_i dropped during SETTLE.
        do_reset();
        acks = 0;
        for (int c = 1; c <= 30; c++) begin
            step(1'b0, (c - 1) < 10, 1'b0);
            acks += int'(off_ack_o);
            if (cyc == 11) begin
                chk("set_abort_state", 32'(state_o), 0);
                chk("set_abort_oen", 32'(pad_oen_o), 'hF);
            end
        end
        chk("set_abort_acks", 32'(acks), 0);

        // en_i dropped during RAMP_UP with two groups enabled.
        do_reset();
        for (int c = 1; c <= 60; c++) begin
            step(1'b0, (c - 1) < 30, 1'b0);
            case (cyc)
                30: chk("up_abort_oen30", 32'(pad_oen_o), 'hC);
                31: chk("up_abort_oen31", 32'(pad_oen_o), 'hE);
                39: chk("up_abort_oen39", 32'(pad_oen_o), 'hF);
                47: begin
                    chk("up_abort_ack47", 32'(off_ack_o), 1);
                    chk("up_abort_state47", 32'(state_o), 0);
                end
                default: ;
            endcase
        end

        // off_req_i overrides en_i in OFF; release starts SETTLE next cycle.
        do_reset();
        for (int c = 1; c <= 10; c++) step(1'b0, 1'b1, 1'b1);
        chk("offreq_hold_state", 32'(state_o), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("offreq_release_state", 32'(state_o), 1);

        // Reset during RAMP_UP returns reset values immediately.
        do_reset();
        for (int c = 1; c <= 29; c++) begin
            step(c == 29, 1'b1, 1'b0);
            if (cyc == 28) chk("mid_rst_pre_state", 32'(state_o), 2);
        end
        chk("mid_rst_oen", 32'(pad_oen_o), 'hF);
        chk("mid_rst_state", 32'(state_o), 0);
        chk("mid_rst_ren", 32'(pad_ren_o), 0);

        // Long randomized run with sticky, occasionally toggling inputs.
        do_reset();
        e = 1'b1;
        o = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(39) == 0) e = ~e;
            if ($urandom_range(59) == 0) o = ~o;
            r = ($urandom_range(299) == 0);
            step(r, e, o);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
